// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the single GPR write port between two writeback
// requesters and tracks pending destinations to produce a hazard stall.
module gpr_wb_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_reg,
  input  logic [4:0]  reg1,
  input  logic [4:0]  reg2,
  output logic        stall,
  output logic        GPRWr,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  logic        last_grant;
  logic [31:0] pend;
  logic        pick0;
  logic        pick1;
  logic        xfer;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;
  logic        hz1;
  logic        hz2;
  logic        hz_iss;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Grant: req0 wins when alone, under fixed priority, or when req1 went last.
  always_comb begin
    pick0 = req0_valid &
            (~req1_valid | (FIXED_PRIO != 1'b0) | last_grant);
    pick1 = req1_valid & ~pick0;
    req0_ready = ~rst & pick0;
    req1_ready = ~rst & pick1;
    xfer = req0_ready | req1_ready;
    sel_reg  = pick1 ? req1_reg  : req0_reg;
    sel_data = pick1 ? req1_data : req0_data;
  end

  // Hazard detect against pending destinations; register 0 never stalls.
  always_comb begin
    hz1    = (reg1 != 5'd0) & pend[reg1];
    hz2    = (reg2 != 5'd0) & pend[reg2];
    hz_iss = iss_valid & (iss_reg != 5'd0) & pend[iss_reg];
    stall  = hz1 | hz2 | hz_iss;
  end

  // Scoreboard update masks: issue sets, committed write clears.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (iss_valid & ~stall & (iss_reg != 5'd0) & ~rst)
      set_mask[iss_reg] = 1'b1;
    if (GPRWr)
      clr_mask[write_reg] = 1'b1;
  end

  // Registered write port, grant history and pending bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      GPRWr      <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
      last_grant <= 1'b1;
      pend       <= 32'd0;
    end else begin
      pend  <= (pend & ~clr_mask) | set_mask;
      GPRWr <= xfer & (sel_reg != 5'd0);
      if (xfer) begin
        last_grant <= pick1;
        write_reg  <= sel_reg;
        write_data <= sel_data;
      end
    end
  end

endmodule
